// File: rtl/sbqm_sensor_tx.sv
// sbqm_sensor_tx: synchronises and debounces the entry/exit photocells into spaced, full/empty-gated up/down pulses.
// Debounce counters are built only when SQBM_DEBOUNCE_EN is defined; otherwise the debounced level follows the synchroniser.
module sbqm_sensor_tx #(
   parameter int DB_CYCLES = 4,
   parameter int DROP_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sens_entry,
   input  logic              sens_exit,
   input  logic              full,
   input  logic              empty,
   output logic              up,
   output logic              down,
   output logic [DROP_W-1:0] drop_cnt
);
   logic [1:0]        sync1_q, sync2_q;
   logic [1:0]        db_q, db_d, dbp_q, arm_q, arm_d, pend_q, pend_d, rise;
   logic              up_q, up_d, down_q, down_d, prio_q, prio_d;
   logic              slot, serve_e, serve_x, blk;
   logic [1:0]        ndrop;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [DROP_W+1:0] drop_sum;

   // Left unreset on purpose: a line held high through reset must still read high afterwards so it never arms.
   always_ff @(posedge clk) begin
      sync1_q <= {sens_exit, sens_entry};
      sync2_q <= sync1_q;
   end

`ifdef SQBM_DEBOUNCE_EN
   localparam logic [3:0] DB = 4'(DB_CYCLES);
   logic [3:0] cnt_q [2];
   logic [3:0] cnt_d [2];

   always_comb begin
      db_d = db_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = 4'd0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB) db_d[i] = ~db_q[i];
            else cnt_d[i] = cnt_q[i] + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '{default: '0};
      else cnt_q <= cnt_d;
   end
`else
   logic unused_db;
   assign unused_db = ^DB_CYCLES;
   always_comb db_d = sync2_q;
`endif

   always_comb begin
      rise     = db_q & ~dbp_q & arm_q;
      arm_d    = arm_q | (~db_q & ~sync2_q);
      slot     = ~up_q & ~down_q;
      // prio_q=0 favours entry; it flips to the other channel after every serve, blocked or not.
      serve_e  = slot & pend_q[0] & (~pend_q[1] | ~prio_q);
      serve_x  = slot & pend_q[1] & (~pend_q[0] | prio_q);
      prio_d   = serve_e ? 1'b1 : serve_x ? 1'b0 : prio_q;
      up_d     = serve_e & ~full;
      down_d   = serve_x & ~empty;
      blk      = (serve_e & full) | (serve_x & empty);
      pend_d   = (pend_q & ~{serve_x, serve_e}) | (rise & ~pend_q);
      ndrop    = 2'(rise[0] & pend_q[0]) + 2'(rise[1] & pend_q[1]) + 2'(blk);
      drop_sum = {2'b00, drop_q} + (DROP_W+2)'(ndrop);
      drop_d   = (|drop_sum[DROP_W+1:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_q   <= '0;
         dbp_q  <= '0;
         arm_q  <= '0;
         pend_q <= '0;
         up_q   <= 1'b0;
         down_q <= 1'b0;
         prio_q <= 1'b0;
         drop_q <= '0;
      end else begin
         db_q   <= db_d;
         dbp_q  <= db_q;
         arm_q  <= arm_d;
         pend_q <= pend_d;
         up_q   <= up_d;
         down_q <= down_d;
         prio_q <= prio_d;
         drop_q <= drop_d;
      end
   end

   assign up       = up_q;
   assign down     = down_q;
   assign drop_cnt = drop_q;
endmodule

// File: tb/tb_sbqm_sensor_tx.sv
// tb_sbqm_sensor_tx: directed scenarios plus random sensor/flag traffic, checked against a per-edge behavioural model
// that works from the raw sample history (debounce window, arming, pend/round-robin service, saturating drops).
module tb_sbqm_sensor_tx;
`ifdef SQBM_DEBOUNCE_EN
   localparam int DBE = 4;
`else
   localparam int DBE = 0;
`endif
   localparam int DMAX = 15;

   logic       clk = 1'b0, rst_n = 1'b0, sens_entry = 1'b0, sens_exit = 1'b0, full = 1'b0, empty = 1'b0;
   logic       up, down;
   logic [3:0] drop_cnt;
   int         total = 0, bad = 0;

   logic [1:0] hist[$];
   bit         m_db[2], m_dbp[2], m_arm[2], m_pend[2];
   bit         m_up, m_down;
   int         m_drop, pref, since;

   sbqm_sensor_tx #(.DB_CYCLES(4), .DROP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .sens_entry(sens_entry), .sens_exit(sens_exit),
      .full(full), .empty(empty), .up(up), .down(down), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_db[c] = 0; m_dbp[c] = 0; m_arm[c] = 0; m_pend[c] = 0;
      end
      m_up = 0; m_down = 0; m_drop = 0; pref = 0; since = 0;
   endtask

   // One clock edge of the reference: raw samples are kept as history, the debounced level flips once the
   // DBE+1 synchronised samples ending two edges back all disagree with it.
   task automatic model_step();
      logic [1:0] r2, w;
      bit rise[2], tog[2], arm_n[2], op[2];
      int sv, n;
      hist.push_back({sens_exit, sens_entry});
      if (hist.size() > 32) void'(hist.pop_front());
      if (!rst_n) begin
         model_reset();
         return;
      end
      r2 = hist[hist.size()-3];
      sv = -1;
      n = 0;
      if (!m_up && !m_down)
         sv = (m_pend[0] && m_pend[1]) ? pref : m_pend[0] ? 0 : m_pend[1] ? 1 : -1;
      for (int c = 0; c < 2; c++) begin
         rise[c]  = m_db[c] && !m_dbp[c] && m_arm[c];
         op[c]    = m_pend[c];
         arm_n[c] = m_arm[c] || (!m_db[c] && !r2[c]);
         tog[c]   = since >= DBE;
         for (int j = 0; j <= DBE; j++) begin
            w = hist[hist.size()-3-j];
            if (tog[c] && w[c] == m_db[c]) tog[c] = 0;
         end
      end
      m_up   = (sv == 0) && !full;
      m_down = (sv == 1) && !empty;
      if (sv >= 0) begin
         if (sv == 0 ? full : empty) n++;
         m_pend[sv] = 0;
         pref = 1 - sv;
      end
      for (int c = 0; c < 2; c++) begin
         if (rise[c]) begin
            if (op[c]) n++;
            else m_pend[c] = 1;
         end
         m_dbp[c] = m_db[c];
         m_db[c]  = m_db[c] ^ tog[c];
         m_arm[c] = arm_n[c];
      end
      m_drop = (m_drop + n > DMAX) ? DMAX : m_drop + n;
      since++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (10) tick();
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (10) tick();
      total++; if (up !== 1'b0) begin bad++; $display("FAIL reset_up got=%b want=0", up); end
      total++; if (down !== 1'b0) begin bad++; $display("FAIL reset_down got=%b want=0", down); end
      total++; if (drop_cnt !== 4'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_reset t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
      end
   endtask

   task automatic test_single_entry();
      int ups = 0, downs = 0, at = -1;
      sens_entry = 1'b1;
      for (int c = 0; c < 35; c++) begin
         if (c == 20) sens_entry = 1'b0;
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_single t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
         if (up) begin ups++; at = c; end
         if (down) downs++;
      end
      total++; if (ups != 1) begin bad++; $display("FAIL single_up_count got=%0d want=1", ups); end
      total++; if (at != 4 + DBE) begin bad++; $display("FAIL single_up_edge got=%0d want=%0d", at, 4 + DBE); end
      total++; if (downs != 0) begin bad++; $display("FAIL single_no_down got=%0d want=0", downs); end
      total++; if (drop_cnt !== 4'd0) begin bad++; $display("FAIL single_drop got=%0d want=0", drop_cnt); end
   endtask

   task automatic test_glitch();
      int downs = 0;
      int exp_downs = (DBE >= 3) ? 0 : 1;
      sens_exit = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c == 3) sens_exit = 1'b0;
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_glitch t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
         if (down) downs++;
      end
      total++; if (downs != exp_downs) begin bad++; $display("FAIL glitch_down got=%0d want=%0d", downs, exp_downs); end
      total++; if (drop_cnt !== 4'd0) begin bad++; $display("FAIL glitch_drop got=%0d want=0", drop_cnt); end
   endtask

   task automatic test_simultaneous();
      int up_at = -1, down_at = -1, both = 0;
      do_reset();
      sens_entry = 1'b1;
      sens_exit  = 1'b1;
      for (int c = 0; c < 35; c++) begin
         if (c == 20) begin sens_entry = 1'b0; sens_exit = 1'b0; end
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_simul t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
         if (up && up_at < 0) up_at = c;
         if (down && down_at < 0) down_at = c;
         if (up && down) both++;
      end
      total++; if (up_at != 4 + DBE) begin bad++; $display("FAIL simul_up_edge got=%0d want=%0d", up_at, 4 + DBE); end
      total++; if (down_at != up_at + 2) begin bad++; $display("FAIL simul_down_edge got=%0d want=%0d", down_at, up_at + 2); end
      total++; if (both != 0) begin bad++; $display("FAIL simul_exclusive got=%0d want=0", both); end
   endtask

   task automatic test_blocked();
      int pulses = 0;
      full = 1'b1;
      sens_entry = 1'b1;
      for (int c = 0; c < 22; c++) begin
         if (c == 10) sens_entry = 1'b0;
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_blk_e t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
         if (up) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL blocked_up got=%0d want=0", pulses); end
      total++; if (drop_cnt !== 4'd1) begin bad++; $display("FAIL blocked_drop1 got=%0d want=1", drop_cnt); end
      full = 1'b0;
      empty = 1'b1;
      sens_exit = 1'b1;
      for (int c = 0; c < 22; c++) begin
         if (c == 10) sens_exit = 1'b0;
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_blk_x t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
         if (down) pulses++;
      end
      empty = 1'b0;
      total++; if (pulses != 0) begin bad++; $display("FAIL blocked_down got=%0d want=0", pulses); end
      total++; if (drop_cnt !== 4'd2) begin bad++; $display("FAIL blocked_drop2 got=%0d want=2", drop_cnt); end
   endtask

   task automatic test_overflow();
      full = 1'b1;
      for (int e = 0; e < 20; e++) begin
         for (int c = 0; c < 16; c++) begin
            sens_entry = (c < 8);
            tick();
            total++;
            if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
               bad++; $display("FAIL model_ovf t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
            end
         end
      end
      full = 1'b0;
      total++; if (drop_cnt !== 4'd15) begin bad++; $display("FAIL overflow_sat got=%0d want=15", drop_cnt); end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      int ups = 0;
      sens_entry = 1'b1;
      for (int c = 0; c < 30 && !seen; c++) begin
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_rmid t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
         if (up) seen = 1;
      end
      total++; if (!seen) begin bad++; $display("FAIL rmid_wait_up got=none want=pulse within 30 cycles"); end
      rst_n = 1'b0;
      #1;
      model_reset();
      total++; if (up !== 1'b0) begin bad++; $display("FAIL rmid_up_cleared got=%b want=0", up); end
      total++; if (drop_cnt !== 4'd0) begin bad++; $display("FAIL rmid_drop_cleared got=%0d want=0", drop_cnt); end
      repeat (3) tick();
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (c == 20) begin
            total++; if (ups != 0) begin bad++; $display("FAIL rmid_held_high got=%0d want=0", ups); end
            ups = 0;
            sens_entry = 1'b0;
         end
         if (c == 30) sens_entry = 1'b1;
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_rmid2 t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
         if (up) ups++;
      end
      total++; if (ups != 1) begin bad++; $display("FAIL rmid_rearm got=%0d want=1", ups); end
      sens_entry = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      int hold[2] = '{1, 1};
      int both = 0;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < 2; k++) begin
            hold[k]--;
            if (hold[k] == 0) begin
               if (k == 0) sens_entry = ~sens_entry;
               else sens_exit = ~sens_exit;
               hold[k] = int'($urandom_range(1, 12));
            end
         end
         if ($urandom_range(0, 9) == 0) full = ~full;
         if ($urandom_range(0, 9) == 0) empty = ~empty;
         tick();
         total++;
         if (up !== m_up || down !== m_down || drop_cnt !== 4'(m_drop)) begin
            bad++; $display("FAIL model_rand t=%0t got %b%b/%0d want %b%b/%0d", $time, up, down, drop_cnt, m_up, m_down, m_drop);
         end
         if (up && down) both++;
      end
      total++; if (both != 0) begin bad++; $display("FAIL rand_exclusive got=%0d want=0", both); end
   endtask

   initial begin
      test_reset();
      test_single_entry();
      test_glitch();
      test_simultaneous();
      test_blocked();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
